lsu_stbuf_queue: RTL and testbench
==================================

// Module: lsu_stbuf_queue
// PURPOSE
//  Store-buffer queue directly upstream of the LSU DCCM/PIC port controller.
//  Holds committed stores (word-aligned, fully merged 32b data) in an in-order circular FIFO.
//  Presents the oldest entry to the port controller and retires it on lsu_stbuf_commit_any.
//  Supplies DC3 load forwarding (youngest-wins byte merge) for the lo and hi word of a load.
// PARAMETERS
//  DEPTH       4   number of entries; power of two, >=2
//  DEPTH_LOG2  2   log2(DEPTH); pointer width
//  ADDR_W      16  DCCM/PIC byte address width held per entry (`RV_DCCM_BITS)
// PORTS
//  clk                     in   1       core clock
//  rst_l                   in   1       asynchronous active-low reset
//  stbuf_wr_en             in   1       enqueue one committed store this cycle
//  stbuf_wr_addr           in   ADDR_W  store byte address; bits [1:0] ignored
//  stbuf_wr_data           in   32      merged full-word store data
//  stbuf_wr_byteen         in   4       bytes actually written by the store (forwarding only)
//  stbuf_wr_in_pic         in   1       store targets PIC
//  lsu_stbuf_commit_any    in   1       port controller accepted head entry this cycle
//  stbuf_reqvld_any        out  1       head entry valid (queue not empty)
//  stbuf_addr_any          out  ADDR_W  head address, bits [1:0] forced 0
//  stbuf_data_any          out  32      head data
//  stbuf_addr_in_pic_any   out  1       head targets PIC
//  stbuf_full_any          out  1       count == DEPTH
//  stbuf_empty_any         out  1       count == 0
//  stbuf_wr_err            out  1       registered 1-cycle pulse: enqueue dropped
//  ld_addr_lo_dc3          in   ADDR_W  DC3 load start address
//  ld_addr_hi_dc3          in   ADDR_W  DC3 load end address
//  ld_in_pic_dc3           in   1       DC3 load targets PIC
//  stbuf_fwddata_lo_dc3    out  32      forwarded data, lo word
//  stbuf_fwddata_hi_dc3    out  32      forwarded data, hi word
//  stbuf_fwdbyteen_lo_dc3  out  4       forwarded byte valids, lo word
//  stbuf_fwdbyteen_hi_dc3  out  4       forwarded byte valids, hi word
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, count=0, all valid bits 0, all entry fields 0.
//    Hence reqvld=0, empty=1, full=0, wr_err=0, head addr/data/pic=0, fwd byteen=0, fwd data=0.
//  - State: wr_ptr, rd_ptr (DEPTH_LOG2 bits, wrap modulo DEPTH), count (DEPTH_LOG2+1 bits), per-entry valid.
//  - Enqueue:
//    - Accepted at posedge when stbuf_wr_en & (~full | deq).
//    - Writes entry[wr_ptr] = {addr[ADDR_W-1:2],2'b0, data, byteen, in_pic}; sets valid; wr_ptr++.
//  - Dequeue: deq = lsu_stbuf_commit_any & reqvld. Clears valid[rd_ptr], rd_ptr++.
//    Commit while empty is ignored; no error.
//  - count next = count + enq - deq. Simultaneous enq+deq: count unchanged, both pointers advance.
//  - Full with simultaneous enqueue and dequeue: enqueue accepted (slot freed same edge).
//  - Overflow: stbuf_wr_en & full & ~deq -> store dropped, state unchanged.
//    stbuf_wr_err=1 for exactly the next cycle.
//  - Head outputs are combinational from entry[rd_ptr]; zero latency from state.
//    An enqueue into an empty queue is visible on stbuf_reqvld_any the cycle after.
//  - Forwarding, combinational from registered state only:
//    - The entry being enqueued this cycle never forwards.
//    - The entry being dequeued this cycle still forwards (valid until the edge).
//    - Entry i matches lo iff valid[i] & in_pic[i]==ld_in_pic_dc3 & addr[i][ADDR_W-1:2]==ld_addr_lo_dc3[ADDR_W-1:2]. Hi is analogous.
//    - Per byte b: fwdbyteen[b] = OR over matching entries of byteen[i][b].
//    - Per byte b: fwddata byte b comes from the youngest matching entry with byteen[b]. Age is distance from rd_ptr; the entry nearest wr_ptr-1 wins.
//    - Bytes with fwdbyteen[b]=0 drive 0 data.
//    - lo and hi are evaluated independently; when they are the same word, the outputs are identical.
//  - Pointer wrap: wr_ptr/rd_ptr DEPTH-1 -> 0. full/empty come from count, not pointer compare.
//  - Async reset mid-operation: all entries are discarded immediately; no commit is issued after reset.
// TESTING
//  1. Reset: rst_l=0 -> reqvld=0, empty=1, full=0, wr_err=0, fwdbyteen_lo/hi=4'h0, addr_any=0.
//  2. Enqueue A=0x0104 D=0x11223344 -> next cycle reqvld=1, addr_any=0x0104, data_any=0x11223344.
//     Then commit=1 one cycle -> empty=1.
//  3. Fill 4 (addrs 0x10,0x14,0x18,0x1C) -> full=1. Fifth wr_en with commit=0 -> wr_err pulses 1 cycle, count stays 4.
//     Fifth wr_en with commit=1 -> accepted, full stays 1, head=0x14.
//  4. Entries to 0x20: older byteen=4'hF data 0xAAAAAAAA, younger byteen=4'h3 data 0x0000BBBB.
//     Load lo=0x22 -> fwdbyteen_lo=4'hF, fwddata_lo=0xAAAABBBB.
//  5. PIC store at 0x0020 (in_pic=1), DCCM load 0x0020 (ld_in_pic=0) -> fwdbyteen=0. Same load with ld_in_pic=1 -> fwdbyteen=byteen.
//  6. Run 10 enq/deq cycles across pointer wrap with simultaneous enq+deq -> FIFO order preserved, count constant.
//     Assert rst_l=0 mid-stream -> reqvld=0 immediately.

Source files
------------

// File: rtl/lsu_stbuf_queue.sv
// rtl/lsu_stbuf_queue.sv - in-order store-buffer FIFO with DC3 byte forwarding
//
// Holds committed, word-aligned, fully merged stores ahead of the DCCM/PIC
// port controller. The oldest entry is presented on the *_any head outputs
// and retires when the port controller accepts it. The DC3 load path gets
// byte-granular forwarding: for each byte, the youngest matching store wins.
//
// Ports:
//   clk, rst_l                  clock, asynchronous active-low reset
//   stbuf_wr_*                  enqueue request (addr, data, byteen, in_pic)
//   lsu_stbuf_commit_any        port controller accepted the head entry
//   stbuf_reqvld_any            head entry valid
//   stbuf_addr_any/data_any     head address (word aligned) and data
//   stbuf_addr_in_pic_any       head targets PIC
//   stbuf_full_any/empty_any    occupancy flags
//   stbuf_wr_err                one-cycle pulse after a dropped enqueue
//   ld_addr_lo/hi_dc3,
//   ld_in_pic_dc3               DC3 load lookup
//   stbuf_fwddata/fwdbyteen_*   forwarded bytes and their valids, lo/hi word
module lsu_stbuf_queue #(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              stbuf_wr_en,
  input  logic [ADDR_W-1:0] stbuf_wr_addr,
  input  logic [31:0]       stbuf_wr_data,
  input  logic [3:0]        stbuf_wr_byteen,
  input  logic              stbuf_wr_in_pic,
  input  logic              lsu_stbuf_commit_any,
  output logic              stbuf_reqvld_any,
  output logic [ADDR_W-1:0] stbuf_addr_any,
  output logic [31:0]       stbuf_data_any,
  output logic              stbuf_addr_in_pic_any,
  output logic              stbuf_full_any,
  output logic              stbuf_empty_any,
  output logic              stbuf_wr_err,
  input  logic [ADDR_W-1:0] ld_addr_lo_dc3,
  input  logic [ADDR_W-1:0] ld_addr_hi_dc3,
  input  logic              ld_in_pic_dc3,
  output logic [31:0]       stbuf_fwddata_lo_dc3,
  output logic [31:0]       stbuf_fwddata_hi_dc3,
  output logic [3:0]        stbuf_fwdbyteen_lo_dc3,
  output logic [3:0]        stbuf_fwdbyteen_hi_dc3
);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH-1:0]      valid;
  logic [ADDR_W-1:0]     addr_q   [DEPTH];
  logic [31:0]           data_q   [DEPTH];
  logic [3:0]            byteen_q [DEPTH];
  logic [DEPTH-1:0]      pic_q;
  logic                  wr_err_q;

  logic enq;
  logic deq;
  logic ovf;

  // Byte offsets inside a word never take part in matching or storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{stbuf_wr_addr[1:0], ld_addr_lo_dc3[1:0], ld_addr_hi_dc3[1:0]};

  assign stbuf_full_any  = (count == CNT_FULL);
  assign stbuf_empty_any = (count == '0);

  assign stbuf_reqvld_any      = valid[rd_ptr];
  assign stbuf_addr_any        = addr_q[rd_ptr];
  assign stbuf_data_any        = data_q[rd_ptr];
  assign stbuf_addr_in_pic_any = pic_q[rd_ptr];
  assign stbuf_wr_err          = wr_err_q;

  // A full queue still accepts a store when the head retires on the same edge.
  assign deq = lsu_stbuf_commit_any & stbuf_reqvld_any;
  assign enq = stbuf_wr_en & (~stbuf_full_any | deq);
  assign ovf = stbuf_wr_en & stbuf_full_any & ~deq;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      valid    <= '0;
      pic_q    <= '0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]   <= '0;
        data_q[i]   <= '0;
        byteen_q[i] <= '0;
      end
    end else begin
      wr_err_q <= ovf;
      // Clear before set: when full, wr_ptr == rd_ptr and the slot must stay valid.
      if (deq) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_ONE;
      end
      if (enq) begin
        valid[wr_ptr]    <= 1'b1;
        addr_q[wr_ptr]   <= {stbuf_wr_addr[ADDR_W-1:2], 2'b00};
        data_q[wr_ptr]   <= stbuf_wr_data;
        byteen_q[wr_ptr] <= stbuf_wr_byteen;
        pic_q[wr_ptr]    <= stbuf_wr_in_pic;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Walk entries oldest to youngest so a later match overwrites an earlier
  // one byte by byte; valid entries are contiguous starting at rd_ptr.
  logic [DEPTH_LOG2-1:0] idx;
  logic                  hit_lo;
  logic                  hit_hi;

  always_comb begin
    stbuf_fwddata_lo_dc3   = '0;
    stbuf_fwddata_hi_dc3   = '0;
    stbuf_fwdbyteen_lo_dc3 = '0;
    stbuf_fwdbyteen_hi_dc3 = '0;
    idx    = '0;
    hit_lo = 1'b0;
    hit_hi = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx    = rd_ptr + DEPTH_LOG2'(k);
      hit_lo = valid[idx] & (pic_q[idx] == ld_in_pic_dc3) &
               (addr_q[idx][ADDR_W-1:2] == ld_addr_lo_dc3[ADDR_W-1:2]);
      hit_hi = valid[idx] & (pic_q[idx] == ld_in_pic_dc3) &
               (addr_q[idx][ADDR_W-1:2] == ld_addr_hi_dc3[ADDR_W-1:2]);
      for (int b = 0; b < 4; b++) begin
        if (hit_lo && byteen_q[idx][b]) begin
          stbuf_fwdbyteen_lo_dc3[b]     = 1'b1;
          stbuf_fwddata_lo_dc3[8*b +: 8] = data_q[idx][8*b +: 8];
        end
        if (hit_hi && byteen_q[idx][b]) begin
          stbuf_fwdbyteen_hi_dc3[b]     = 1'b1;
          stbuf_fwddata_hi_dc3[8*b +: 8] = data_q[idx][8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_stbuf_queue.sv
// tb/tb_lsu_stbuf_queue.sv - scoreboard bench for lsu_stbuf_queue
module tb_lsu_stbuf_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        stbuf_wr_en;
  logic [15:0] stbuf_wr_addr;
  logic [31:0] stbuf_wr_data;
  logic [3:0]  stbuf_wr_byteen;
  logic        stbuf_wr_in_pic;
  logic        lsu_stbuf_commit_any;
  logic        stbuf_reqvld_any;
  logic [15:0] stbuf_addr_any;
  logic [31:0] stbuf_data_any;
  logic        stbuf_addr_in_pic_any;
  logic        stbuf_full_any;
  logic        stbuf_empty_any;
  logic        stbuf_wr_err;
  logic [15:0] ld_addr_lo_dc3;
  logic [15:0] ld_addr_hi_dc3;
  logic        ld_in_pic_dc3;
  logic [31:0] stbuf_fwddata_lo_dc3;
  logic [31:0] stbuf_fwddata_hi_dc3;
  logic [3:0]  stbuf_fwdbyteen_lo_dc3;
  logic [3:0]  stbuf_fwdbyteen_hi_dc3;

  lsu_stbuf_queue #(.DEPTH(4), .DEPTH_LOG2(2), .ADDR_W(16)) dut (
    .clk(clk), .rst_l(rst_l),
    .stbuf_wr_en(stbuf_wr_en), .stbuf_wr_addr(stbuf_wr_addr),
    .stbuf_wr_data(stbuf_wr_data), .stbuf_wr_byteen(stbuf_wr_byteen),
    .stbuf_wr_in_pic(stbuf_wr_in_pic), .lsu_stbuf_commit_any(lsu_stbuf_commit_any),
    .stbuf_reqvld_any(stbuf_reqvld_any), .stbuf_addr_any(stbuf_addr_any),
    .stbuf_data_any(stbuf_data_any), .stbuf_addr_in_pic_any(stbuf_addr_in_pic_any),
    .stbuf_full_any(stbuf_full_any), .stbuf_empty_any(stbuf_empty_any),
    .stbuf_wr_err(stbuf_wr_err),
    .ld_addr_lo_dc3(ld_addr_lo_dc3), .ld_addr_hi_dc3(ld_addr_hi_dc3),
    .ld_in_pic_dc3(ld_in_pic_dc3),
    .stbuf_fwddata_lo_dc3(stbuf_fwddata_lo_dc3), .stbuf_fwddata_hi_dc3(stbuf_fwddata_hi_dc3),
    .stbuf_fwdbyteen_lo_dc3(stbuf_fwdbyteen_lo_dc3), .stbuf_fwdbyteen_hi_dc3(stbuf_fwdbyteen_hi_dc3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        pic;
  } ent_t;

  typedef struct {
    logic        reqvld;
    logic        empty;
    logic        full;
    logic        err;
    logic        pic;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  fblo;
    logic [31:0] fdlo;
    logic [3:0]  fbhi;
    logic [31:0] fdhi;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  logic model_err;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Youngest-wins byte merge over the model queue (front = oldest).
  function automatic void fwd(input logic [15:0] la, input logic lp,
                              output logic [3:0] be, output logic [31:0] d);
    be = 4'h0;
    d  = 32'h0;
    foreach (mq[i]) begin
      if (mq[i].pic == lp && mq[i].addr[15:2] == la[15:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (mq[i].be[b]) begin
            be[b]       = 1'b1;
            d[8*b +: 8] = mq[i].data[8*b +: 8];
          end
        end
      end
    end
  endfunction

  // Drives one cycle of stimulus, predicts this cycle's outputs, then
  // advances the model across the coming clock edge.
  task automatic drive(input logic we, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic pic, input logic cm,
                       input logic [15:0] llo, input logic [15:0] lhi, input logic lpic);
    exp_t e;
    ent_t n;
    logic deq_m;
    logic enq_m;
    @(negedge clk);
    stbuf_wr_en          = we;
    stbuf_wr_addr        = a;
    stbuf_wr_data        = d;
    stbuf_wr_byteen      = be;
    stbuf_wr_in_pic      = pic;
    lsu_stbuf_commit_any = cm;
    ld_addr_lo_dc3       = llo;
    ld_addr_hi_dc3       = lhi;
    ld_in_pic_dc3        = lpic;
    e.reqvld = (mq.size() > 0);
    e.empty  = (mq.size() == 0);
    e.full   = (mq.size() == DEPTH);
    e.err    = model_err;
    e.addr   = 16'h0;
    e.data   = 32'h0;
    e.pic    = 1'b0;
    if (e.reqvld) begin
      e.addr = {mq[0].addr[15:2], 2'b00};
      e.data = mq[0].data;
      e.pic  = mq[0].pic;
    end
    fwd(llo, lpic, e.fblo, e.fdlo);
    fwd(lhi, lpic, e.fbhi, e.fdhi);
    exp_q.push_back(e);
    deq_m     = cm && (mq.size() > 0);
    enq_m     = we && (!e.full || deq_m);
    model_err = we && e.full && !deq_m;
    if (deq_m) void'(mq.pop_front());
    if (enq_m) begin
      n.addr = a; n.data = d; n.be = be; n.pic = pic;
      mq.push_back(n);
    end
    #2;
  endtask

  task automatic idle(input logic cm);
    drive(1'b0, 16'h0, 32'h0, 4'h0, 1'b0, cm, 16'h0, 16'h0, 1'b0);
  endtask

  // Monitor: compares the DUT against each predicted cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("reqvld", 32'(stbuf_reqvld_any), 32'(e.reqvld));
        chk("empty", 32'(stbuf_empty_any), 32'(e.empty));
        chk("full", 32'(stbuf_full_any), 32'(e.full));
        chk("wr_err", 32'(stbuf_wr_err), 32'(e.err));
        if (e.reqvld) begin
          chk("head_addr", 32'(stbuf_addr_any), 32'(e.addr));
          chk("head_data", stbuf_data_any, e.data);
          chk("head_pic", 32'(stbuf_addr_in_pic_any), 32'(e.pic));
        end
        chk("fwdbyteen_lo", 32'(stbuf_fwdbyteen_lo_dc3), 32'(e.fblo));
        chk("fwddata_lo", stbuf_fwddata_lo_dc3, e.fdlo);
        chk("fwdbyteen_hi", 32'(stbuf_fwdbyteen_hi_dc3), 32'(e.fbhi));
        chk("fwddata_hi", stbuf_fwddata_hi_dc3, e.fdhi);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        we, cm, pic, lpic;
    logic [15:0] a, llo;
    rst_l = 1'b0;
    model_err = 1'b0;
    stbuf_wr_en = 0; stbuf_wr_addr = 0; stbuf_wr_data = 0; stbuf_wr_byteen = 0;
    stbuf_wr_in_pic = 0; lsu_stbuf_commit_any = 0;
    ld_addr_lo_dc3 = 0; ld_addr_hi_dc3 = 0; ld_in_pic_dc3 = 0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_reqvld", 32'(stbuf_reqvld_any), 32'd0);
    chk("rst_empty", 32'(stbuf_empty_any), 32'd1);
    chk("rst_full", 32'(stbuf_full_any), 32'd0);
    chk("rst_wr_err", 32'(stbuf_wr_err), 32'd0);
    chk("rst_fwdbyteen_lo", 32'(stbuf_fwdbyteen_lo_dc3), 32'd0);
    chk("rst_fwdbyteen_hi", 32'(stbuf_fwdbyteen_hi_dc3), 32'd0);
    chk("rst_addr_any", 32'(stbuf_addr_any), 32'd0);
    #1 rst_l = 1'b1;

    // Single enqueue then commit
    drive(1, 16'h0104, 32'h11223344, 4'hF, 0, 0, 16'h0, 16'h0, 0);
    idle(0);
    chk("t2_reqvld", 32'(stbuf_reqvld_any), 32'd1);
    chk("t2_addr", 32'(stbuf_addr_any), 32'h0104);
    chk("t2_data", stbuf_data_any, 32'h11223344);
    idle(1);
    idle(0);
    chk("t2_empty", 32'(stbuf_empty_any), 32'd1);

    // Fill, overflow, full with simultaneous enq+deq
    for (int i = 0; i < 4; i++)
      drive(1, 16'(16'h10 + 4*i), $urandom, 4'hF, 0, 0, 16'h0, 16'h0, 0);
    idle(0);
    chk("t3_full", 32'(stbuf_full_any), 32'd1);
    drive(1, 16'h30, 32'hDEADBEEF, 4'hF, 0, 0, 16'h0, 16'h0, 0);
    idle(0);
    chk("t3_wr_err_pulse", 32'(stbuf_wr_err), 32'd1);
    idle(0);
    chk("t3_wr_err_clear", 32'(stbuf_wr_err), 32'd0);
    chk("t3_still_full", 32'(stbuf_full_any), 32'd1);
    drive(1, 16'h34, 32'h0BADF00D, 4'hF, 0, 1, 16'h0, 16'h0, 0);
    idle(0);
    chk("t3_full_after_swap", 32'(stbuf_full_any), 32'd1);
    chk("t3_head_0x14", 32'(stbuf_addr_any), 32'h0014);
    repeat (4) idle(1);
    idle(0);
    chk("t3_drained", 32'(stbuf_empty_any), 32'd1);

    // Youngest-wins byte merge
    drive(1, 16'h20, 32'hAAAAAAAA, 4'hF, 0, 0, 16'h0, 16'h0, 0);
    drive(1, 16'h20, 32'h0000BBBB, 4'h3, 0, 0, 16'h0, 16'h0, 0);
    drive(0, 16'h0, 32'h0, 4'h0, 0, 0, 16'h22, 16'h22, 0);
    chk("t4_fwdbyteen_lo", 32'(stbuf_fwdbyteen_lo_dc3), 32'hF);
    chk("t4_fwddata_lo", stbuf_fwddata_lo_dc3, 32'hAAAABBBB);
    chk("t4_fwddata_hi", stbuf_fwddata_hi_dc3, 32'hAAAABBBB);
    repeat (2) idle(1);

    // PIC vs DCCM isolation
    drive(1, 16'h20, 32'h55667788, 4'h6, 1, 0, 16'h0, 16'h0, 0);
    drive(0, 16'h0, 32'h0, 4'h0, 0, 0, 16'h20, 16'h20, 0);
    chk("t5_dccm_load_no_fwd", 32'(stbuf_fwdbyteen_lo_dc3), 32'h0);
    drive(0, 16'h0, 32'h0, 4'h0, 0, 0, 16'h20, 16'h20, 1);
    chk("t5_pic_load_byteen", 32'(stbuf_fwdbyteen_lo_dc3), 32'h6);
    chk("t5_pic_load_data", stbuf_fwddata_lo_dc3, 32'h00667700);
    idle(1);

    // Steady enq+deq across pointer wrap, then async reset mid-stream
    drive(1, 16'h40, $urandom, 4'hF, 0, 0, 16'h0, 16'h0, 0);
    drive(1, 16'h44, $urandom, 4'hF, 0, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 10; i++)
      drive(1, 16'(16'h50 + 4*i), $urandom, 4'(i), 0, 1, 16'(16'h50 + 4*i), 16'h44, 0);
    #1 rst_l = 1'b0;
    #1;
    chk("t6_reset_reqvld", 32'(stbuf_reqvld_any), 32'd0);
    chk("t6_reset_empty", 32'(stbuf_empty_any), 32'd1);
    mq.delete();
    model_err = 1'b0;
    stbuf_wr_en = 0; lsu_stbuf_commit_any = 0;
    @(negedge clk);
    #3 rst_l = 1'b1;
    idle(1);

    // Randomised traffic in two pressure regimes
    for (int i = 0; i < 400; i++) begin
      we   = (i < 200) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 40);
      cm   = (i < 200) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 60);
      a    = 16'(16'h20 + $urandom_range(0, 15));
      pic  = ($urandom_range(0, 7) == 0);
      llo  = 16'(16'h20 + $urandom_range(0, 15));
      lpic = ($urandom_range(0, 7) == 0);
      drive(we, a, $urandom, 4'($urandom_range(0, 15)), pic, cm,
            llo, 16'(llo + 16'($urandom_range(0, 3))), lpic);
    end
    repeat (2) idle(0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
